// File: rtl/beep_scheduler.sv
// beep_scheduler
//   Owns the single board buzzer. It arbitrates between the reversing
//   alarm, key-click feedback and the mode-change chirp, then steps the
//   granted source through its on/off pattern and drives the buzzer with a
//   square wave.
//
// Ports
//   sys_clk     system clock (50 MHz)
//   sys_rst     synchronous reset, active-high
//   alarm_en    level, alarm source enabled
//   dis         measured distance, sampled at the alarm ON->OFF boundary
//   click_req   one-cycle pulse, request a key click
//   chirp_req   one-cycle pulse, request a chirp sequence
//   beep        buzzer drive (registered)
//   active_src  0 none, 1 alarm, 2 click, 3 chirp (registered)
//   busy        high whenever active_src != 0 (registered)
module beep_scheduler #(
  parameter int unsigned ALARM_ON_CYC = 5_000_000,
  parameter int unsigned DIS_NEAR     = 5000,
  parameter int unsigned DIS_FAR      = 100000,
  parameter int unsigned DIS_SCALE    = 750,
  parameter int unsigned CLICK_CYC    = 1_000_000,
  parameter int unsigned CHIRP_CYC    = 2_500_000,
  parameter int unsigned CHIRP_N      = 3,
  parameter int unsigned ALARM_HALF   = 27408,
  parameter int unsigned CLICK_HALF   = 20000,
  parameter int unsigned CHIRP_HALF   = 13704
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        alarm_en,
  input  logic [18:0] dis,
  input  logic        click_req,
  input  logic        chirp_req,
  output logic        beep,
  output logic [1:0]  active_src,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_ALM_ON, S_ALM_OFF, S_CLICK, S_CHIRP_ON, S_CHIRP_GAP
  } state_t;

  localparam logic [29:0] ALM_LAST   = 30'(ALARM_ON_CYC - 1);
  localparam logic [29:0] CLICK_LAST = 30'(CLICK_CYC - 1);
  localparam logic [29:0] CHIRP_LAST = 30'(CHIRP_CYC - 1);
  localparam logic [29:0] SCALE_W    = 30'(DIS_SCALE);
  localparam logic [18:0] NEAR_W     = 19'(DIS_NEAR);
  localparam logic [18:0] FAR_W      = 19'(DIS_FAR);
  localparam logic [2:0]  CHIRP_IDX_LAST = 3'(CHIRP_N - 1);

  state_t      state_q, state_d;
  logic [29:0] cnt_q, cnt_d;          // cycles spent in the current state
  logic [29:0] off_len_q, off_len_d;  // alarm silent length, latched at ON->OFF
  logic [15:0] tone_cnt_q, tone_cnt_d;
  logic [2:0]  idx_q, idx_d;          // chirp tone index
  logic        click_pend_q, click_pend_d;
  logic        chirp_pend_q, chirp_pend_d;
  logic        beep_q, beep_d;
  logic [1:0]  src_q, src_d;
  logic        busy_q, busy_d;

  logic        enter;                 // a (re)entry into a state this cycle
  logic        alarm_req, click_want, chirp_want;
  logic [29:0] off_prod;

  function automatic logic is_tone(input state_t s);
    return (s == S_ALM_ON) || (s == S_CLICK) || (s == S_CHIRP_ON);
  endfunction

  function automatic logic [15:0] half_last(input state_t s);
    case (s)
      S_ALM_ON: return 16'(ALARM_HALF - 1);
      S_CLICK:  return 16'(CLICK_HALF - 1);
      default:  return 16'(CHIRP_HALF - 1);
    endcase
  endfunction

  function automatic logic [1:0] src_of(input state_t s);
    case (s)
      S_ALM_ON, S_ALM_OFF:     return 2'd1;
      S_CLICK:                 return 2'd2;
      S_CHIRP_ON, S_CHIRP_GAP: return 2'd3;
      default:                 return 2'd0;
    endcase
  endfunction

  assign alarm_req = alarm_en && (dis < FAR_W);
  assign off_prod  = 30'(dis) * SCALE_W;

  // Requests for the source that already owns the buzzer are dropped.
  assign chirp_want = chirp_pend_q |
                      (chirp_req & (state_q != S_CHIRP_ON) & (state_q != S_CHIRP_GAP));
  assign click_want = click_pend_q | (click_req & (state_q != S_CLICK));

  always_comb begin
    state_d      = state_q;
    enter        = 1'b0;
    off_len_d    = off_len_q;
    idx_d        = idx_q;
    chirp_pend_d = chirp_want;
    click_pend_d = click_want;

    case (state_q)
      // IDLE and both alarm states re-arbitrate every cycle, so a chirp or
      // click preempts the alarm immediately.
      S_IDLE, S_ALM_ON, S_ALM_OFF: begin
        if (chirp_want) begin
          state_d      = S_CHIRP_ON;
          idx_d        = 3'd0;
          chirp_pend_d = 1'b0;
          enter        = 1'b1;
        end else if (click_want) begin
          state_d      = S_CLICK;
          click_pend_d = 1'b0;
          enter        = 1'b1;
        end else if (!alarm_req) begin
          state_d = S_IDLE;
          enter   = (state_q != S_IDLE);
        end else if (state_q == S_IDLE) begin
          state_d = S_ALM_ON;
          enter   = 1'b1;
        end else if (state_q == S_ALM_ON) begin
          if (cnt_q == ALM_LAST) begin
            enter = 1'b1;
            if (dis <= NEAR_W) begin
              state_d = S_ALM_ON;      // continuous tone, restart without gap
            end else begin
              off_len_d = off_prod;
              state_d   = S_ALM_OFF;
            end
          end
        end else if (cnt_q + 30'd1 >= off_len_q) begin
          state_d = S_ALM_ON;
          enter   = 1'b1;
        end
      end
      S_CLICK: begin
        if (cnt_q == CLICK_LAST) begin
          state_d = S_IDLE;
          enter   = 1'b1;
        end
      end
      S_CHIRP_ON: begin
        if (cnt_q == CHIRP_LAST) begin
          enter   = 1'b1;
          state_d = (idx_q == CHIRP_IDX_LAST) ? S_IDLE : S_CHIRP_GAP;
        end
      end
      S_CHIRP_GAP: begin
        if (cnt_q == CHIRP_LAST) begin
          enter   = 1'b1;
          state_d = S_CHIRP_ON;
          idx_d   = idx_q + 3'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        enter   = 1'b1;
      end
    endcase

    cnt_d = (enter || state_d == S_IDLE) ? 30'd0 : cnt_q + 30'd1;

    // Tone generator: every entry starts the square wave low from phase 0.
    if (!is_tone(state_d) || enter) begin
      tone_cnt_d = 16'd0;
      beep_d     = 1'b0;
    end else if (tone_cnt_q == half_last(state_q)) begin
      tone_cnt_d = 16'd0;
      beep_d     = ~beep_q;
    end else begin
      tone_cnt_d = tone_cnt_q + 16'd1;
      beep_d     = beep_q;
    end

    src_d  = src_of(state_d);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= 30'd0;
      off_len_q    <= 30'd0;
      tone_cnt_q   <= 16'd0;
      idx_q        <= 3'd0;
      click_pend_q <= 1'b0;
      chirp_pend_q <= 1'b0;
      beep_q       <= 1'b0;
      src_q        <= 2'd0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      off_len_q    <= off_len_d;
      tone_cnt_q   <= tone_cnt_d;
      idx_q        <= idx_d;
      click_pend_q <= click_pend_d;
      chirp_pend_q <= chirp_pend_d;
      beep_q       <= beep_d;
      src_q        <= src_d;
      busy_q       <= busy_d;
    end
  end

  assign beep       = beep_q;
  assign active_src = src_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_beep_scheduler.sv
// Testbench for beep_scheduler with shortened timing parameters. A
// segment-level reference model (source, tone/silent, length, elapsed time)
// predicts the outputs every cycle; beep is derived arithmetically from the
// elapsed time within a tone segment.
module tb_beep_scheduler;

  localparam int P_ALARM_ON   = 100;
  localparam int P_SCALE      = 2;
  localparam int P_NEAR       = 50;
  localparam int P_FAR        = 1000;
  localparam int P_CLICK_CYC  = 40;
  localparam int P_CHIRP_CYC  = 30;
  localparam int P_CHIRP_N    = 3;
  localparam int P_ALARM_HALF = 5;
  localparam int P_CLICK_HALF = 4;
  localparam int P_CHIRP_HALF = 3;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        alarm_en;
  logic [18:0] dis;
  logic        click_req;
  logic        chirp_req;
  logic        beep;
  logic [1:0]  active_src;
  logic        busy;

  beep_scheduler #(
    .ALARM_ON_CYC(P_ALARM_ON), .DIS_NEAR(P_NEAR), .DIS_FAR(P_FAR),
    .DIS_SCALE(P_SCALE), .CLICK_CYC(P_CLICK_CYC), .CHIRP_CYC(P_CHIRP_CYC),
    .CHIRP_N(P_CHIRP_N), .ALARM_HALF(P_ALARM_HALF),
    .CLICK_HALF(P_CLICK_HALF), .CHIRP_HALF(P_CHIRP_HALF)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .alarm_en(alarm_en), .dis(dis),
    .click_req(click_req), .chirp_req(chirp_req), .beep(beep),
    .active_src(active_src), .busy(busy)
  );

  always #5 sys_clk = ~sys_clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: current segment of buzzer ownership.
  int m_src, m_t, m_len, m_half, m_k;
  bit m_tone, m_click_p, m_chirp_p;

  // Observation counters for directed windows.
  int   n_tog, n_src2, n_idle;
  logic prev_beep;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s t=%0t observed=%0d expected=%0d", tag, $time, obs, exp);
    end
  endtask

  task automatic seg(input int src, input bit tone, input int len, input int half);
    m_src = src; m_tone = tone; m_len = len; m_half = half; m_t = 0;
  endtask

  task automatic model_step();
    bit areq, cw, kw, last;
    if (sys_rst) begin
      seg(0, 0, 1, 1);
      m_k = 0; m_click_p = 0; m_chirp_p = 0;
      return;
    end
    areq = alarm_en && (int'(dis) < P_FAR);
    cw   = m_chirp_p || (chirp_req && m_src != 3);
    kw   = m_click_p || (click_req && m_src != 2);
    m_chirp_p = cw;
    m_click_p = kw;
    last = (m_t == m_len - 1);
    if (m_src <= 1) begin
      if (cw) begin
        seg(3, 1, P_CHIRP_CYC, P_CHIRP_HALF); m_k = 0; m_chirp_p = 0;
      end else if (kw) begin
        seg(2, 1, P_CLICK_CYC, P_CLICK_HALF); m_click_p = 0;
      end else if (!areq) begin
        seg(0, 0, 1, 1);
      end else if (m_src == 0 || last) begin
        if (m_src == 1 && m_tone && int'(dis) > P_NEAR)
          seg(1, 0, int'(dis) * P_SCALE, 1);
        else
          seg(1, 1, P_ALARM_ON, P_ALARM_HALF);
      end else begin
        m_t++;
      end
    end else if (!last) begin
      m_t++;
    end else if (m_src == 2) begin
      seg(0, 0, 1, 1);
    end else if (m_tone) begin
      if (m_k == P_CHIRP_N - 1) seg(0, 0, 1, 1);
      else seg(3, 0, P_CHIRP_CYC, 1);
    end else begin
      m_k++;
      seg(3, 1, P_CHIRP_CYC, P_CHIRP_HALF);
    end
  endtask

  // Advance n clock cycles, checking every output against the model.
  task automatic cyc(input int n);
    logic exp_beep;
    for (int i = 0; i < n; i++) begin
      model_step();
      exp_beep = m_tone && (((m_t / m_half) % 2) == 1);
      @(posedge sys_clk);
      #1;
      check("beep", 32'(beep), 32'(exp_beep));
      check("active_src", 32'(active_src), 32'(m_src));
      check("busy", 32'(busy), 32'(m_src != 0));
      if (beep !== prev_beep) n_tog++;
      prev_beep = beep;
      if (active_src == 2'd2) n_src2++;
      if (busy == 1'b0) n_idle++;
      click_req = 1'b0;
      chirp_req = 1'b0;
    end
  endtask

  task automatic clear_counts();
    n_tog = 0; n_src2 = 0; n_idle = 0; prev_beep = beep;
  endtask

  initial begin
    sys_rst = 1'b1; alarm_en = 1'b0; dis = 19'd0;
    click_req = 1'b0; chirp_req = 1'b0;
    prev_beep = 1'b0;
    seg(0, 0, 1, 1); m_k = 0; m_click_p = 0; m_chirp_p = 0;

    // Reset state
    cyc(3);
    check("rst_beep", 32'(beep), 32'd0);
    check("rst_src", 32'(active_src), 32'd0);
    sys_rst = 1'b0;
    cyc(5);

    // Click from IDLE, second pulse inside the window dropped
    clear_counts();
    click_req = 1'b1; cyc(1);
    cyc(10);
    click_req = 1'b1; cyc(1);
    cyc(33);
    check("click_src_cycles", 32'(n_src2), 32'd40);
    check("click_toggles", 32'(n_tog), 32'd10);
    cyc(10);

    // Alarm at dis=200, then dis=300 during OFF
    alarm_en = 1'b1; dis = 19'd200;
    cyc(150);
    dis = 19'd300;
    cyc(1200);
    alarm_en = 1'b0;
    cyc(5);

    // Near distance: continuous tone; far distance / disable drops to IDLE
    alarm_en = 1'b1; dis = 19'd40;
    cyc(250);
    dis = 19'd1000;
    cyc(3);
    check("far_idle", 32'(active_src), 32'd0);
    dis = 19'd40;
    cyc(20);
    alarm_en = 1'b0;
    cyc(3);

    // Simultaneous click+chirp preempting the alarm
    alarm_en = 1'b1; dis = 19'd200;
    cyc(30);
    click_req = 1'b1; chirp_req = 1'b1;
    cyc(1);
    check("preempt_src", 32'(active_src), 32'd3);
    cyc(300);
    alarm_en = 1'b0;
    cyc(5);

    // Chirp requested during a click waits one IDLE cycle
    clear_counts();
    click_req = 1'b1; cyc(1);
    cyc(9);
    chirp_req = 1'b1; cyc(1);
    cyc(29);
    cyc(151);
    check("click_chirp_idle_cycles", 32'(n_idle), 32'd1);
    cyc(5);

    // Reset held mid-chirp, then silence
    chirp_req = 1'b1; cyc(1);
    cyc(50);
    sys_rst = 1'b1;
    cyc(3);
    sys_rst = 1'b0;
    clear_counts();
    cyc(20);
    check("post_rst_idle_cycles", 32'(n_idle), 32'd20);

    // Randomized traffic
    alarm_en = 1'b1; dis = 19'd30;
    for (int i = 0; i < 5000; i++) begin
      if ($urandom_range(0, 299) == 0) alarm_en = ~alarm_en;
      if ($urandom_range(0, 199) == 0) dis = 19'($urandom_range(0, 1100));
      click_req = ($urandom_range(0, 149) == 0);
      chirp_req = ($urandom_range(0, 399) == 0);
      sys_rst   = ($urandom_range(0, 1999) == 0);
      cyc(1);
    end
    sys_rst = 1'b0;
    cyc(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/beep_scheduler.md
Name: beep_scheduler

Overview:
- Arbitrates the single board buzzer between three sources: the distance (reversing) alarm, key-click feedback and a mode-change chirp.
- Each granted source is sequenced through its on/off pattern, and the block generates the square-wave buzzer drive directly.
- Sits between the distance-measurement/key-decode logic and the buzzer pin. It replaces direct buzzer toggling elsewhere.

Parameters:
- ALARM_ON_CYC, 5_000_000, alarm tone-on length in cycles (100 ms at 50 MHz).
- DIS_NEAR, 5000, dis at or below this gives a continuous alarm tone.
- DIS_FAR, 100000, dis at or above this gives no alarm.
- DIS_SCALE, 750, alarm off-time cycles per dis unit.
- CLICK_CYC, 1_000_000, key-click tone length.
- CHIRP_CYC, 2_500_000, chirp tone length and gap length.
- CHIRP_N, 3, number of chirp tones (1..7).
- ALARM_HALF, 27408, alarm tone half-period in cycles.
- CLICK_HALF, 20000, click tone half-period.
- CHIRP_HALF, 13704, chirp tone half-period.

Ports:
- sys_clk  in  1  system clock, 50 MHz
- sys_rst  in  1  synchronous reset, active-high
- alarm_en  in  1  level; alarm source enabled (key-controlled)
- dis  in  19  measured distance, sampled as described below
- click_req  in  1  one-cycle pulse; request a key click
- chirp_req  in  1  one-cycle pulse; request a chirp sequence
- beep  out  1  buzzer drive
- active_src  out  2  source owning the buzzer: 0 none, 1 alarm, 2 click, 3 chirp
- busy  out  1  high when active_src != 0

Behaviour:
- Reset (sync, active-high): state IDLE; all counters 0; pending flags 0; beep=0; active_src=0; busy=0. Reset asserted mid-sequence aborts it; beep=0 the cycle after reset is sampled.
- Pending flags:
  - click_req sets click_pend; chirp_req sets chirp_pend.
  - A pulse arriving while that same source is active is dropped.
  - A flag is cleared on the cycle its source is granted.
- alarm_req (internal) = alarm_en && dis < DIS_FAR.
- Priority: chirp > click > alarm. Arbitration happens in IDLE and at every cycle of ALM_ON/ALM_OFF.
  - A pending chirp or click preempts the alarm immediately: next cycle enters CHIRP_ON/CLICK.
  - Click and chirp are never preempted. A request arriving during them waits.
  - Simultaneous click and chirp pulses: chirp served first, then click.
- States:
  - IDLE: grant highest pending/requesting source. Chirp -> CHIRP_ON (tone index 0); click -> CLICK; alarm -> ALM_ON.
  - ALM_ON: tone ALARM_HALF for ALARM_ON_CYC cycles. At the last cycle:
    - if dis <= DIS_NEAR, restart ALM_ON (continuous tone, no gap);
    - else latch off_len = dis*DIS_SCALE (30-bit unsigned product, no truncation) and go to ALM_OFF.
  - ALM_OFF: silent for off_len cycles, then ALM_ON. dis is sampled only at the ON->OFF boundary.
  - CLICK: tone CLICK_HALF for CLICK_CYC cycles, then IDLE.
  - CHIRP_ON: tone CHIRP_HALF for CHIRP_CYC cycles. Then go to CHIRP_GAP, or to IDLE after tone CHIRP_N-1.
  - CHIRP_GAP: silent CHIRP_CYC cycles, then CHIRP_ON with index+1.
  - Any alarm state with alarm_req=0: IDLE next cycle, beep=0.
- Return to IDLE costs one cycle before the next grant. Alarm resumes from ALM_ON start after preemption.
- Tone generator:
  - On every entry into a tone state (including ALM_ON restart): tone_cnt=0, beep=0.
  - In a tone state, tone_cnt counts 0..HALF-1. At HALF-1, beep toggles and tone_cnt wraps to 0.
  - In non-tone states, beep=0.
- Outputs are registered. active_src/busy update the same cycle as the state register.

Test Plan (bench overrides: ALARM_ON_CYC=100, DIS_SCALE=2, DIS_NEAR=50, DIS_FAR=1000, CLICK_CYC=40, CHIRP_CYC=30, CHIRP_N=3, halves 5/4/3):
- Reset held 3 cycles mid-chirp -> beep=0, active_src=0, busy=0; no activity until a new request.
- click_req pulse from IDLE -> active_src=2 for 40 cycles; beep toggles every 4 cycles (10 toggles); then IDLE; second click pulse inside the window is dropped.
- alarm_en=1, dis=200 -> repeating 100 cycles of toggling every 5, then 400 silent cycles. dis changed to 300 during OFF takes effect only from the next OFF (600 cycles).
- alarm_en=1, dis=40 -> beep toggles continuously every 5 cycles with no silent gap. dis=1000 or alarm_en=0 -> IDLE next cycle, beep=0.
- Alarm in ALM_ON, then click_req and chirp_req pulse together -> next cycle active_src=3. Three 30-cycle tones with 30-cycle gaps, then one IDLE cycle, then click (40), then IDLE, then alarm restarts at ALM_ON.
- chirp_req during click -> click completes its 40 cycles, IDLE one cycle, then chirp; busy stays high except that IDLE cycle.
